// File: rtl/quad_decoder.sv
// Quadrature decoder. Synchronizes the A/B inputs, absorbs the power-up phase, and then
// turns each Gray-code transition into a step on a wrapping position counter.
module quad_decoder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a,
  input  logic         b,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] pos,
  output logic         step,
  output logic         dir,
  output logic         err,
  output logic         max_tick,
  output logic         min_tick
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [1:0]   s1_q, s2_q, prev_q;
  logic [1:0]   fill_q, fill_d;
  logic [N-1:0] pos_q, pos_d;
  logic         step_q, step_d;
  logic         dir_q, dir_d;
  logic         err_q, err_d;
  logic         up, down, illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      fill_q  <= '0;
      pos_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= {a, b};
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      fill_q  <= fill_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  // Transitions are decoded as {prev,s2}, each pair written as {a,b}.
  always_comb begin
    up      = 1'b0;
    down    = 1'b0;
    illegal = 1'b0;
    if (state_q == RUN) begin
      case ({prev_q, s2_q})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up      = 1'b1;
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: down    = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    pos_d   = pos_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q | illegal;

    case (state_q)
      INIT: begin
        fill_d = fill_q + 2'd1;
        if (fill_q == 2'd2) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase

    // A step that coincides with clr or load is dropped, not deferred.
    if (clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end else if (load) begin
      pos_d = d;
    end else if (en && (up || down)) begin
      pos_d  = up ? pos_q + ONE : pos_q - ONE;
      step_d = 1'b1;
      dir_d  = up;
    end
  end

  assign pos      = pos_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign max_tick = (pos_q == '1);
  assign min_tick = (pos_q == '0);

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder. A reference model that counts edges since reset
// and works on Gray-code phase indices predicts pos/step/dir/err every cycle.
module tb_quad_decoder;

  logic       clk = 1'b0, reset = 1'b1;
  logic       a = 1'b0, b = 1'b0, en = 1'b0, clr = 1'b0, load = 1'b0;
  logic [7:0] d = '0;
  logic [7:0] pos;
  logic       step, dir, err, max_tick, min_tick;

  int checks = 0;
  int errors = 0;

  quad_decoder #(.N(8)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .en(en), .clr(clr), .load(load), .d(d),
    .pos(pos), .step(step), .dir(dir), .err(err), .max_tick(max_tick), .min_tick(min_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Reference model. The value at edge e is ab[e]; edge e (counted from reset release)
  // decodes ab[e-3] -> ab[e-2] once e >= 4.
  logic [7:0] m_pos = '0;
  logic       m_step = 1'b0, m_dir = 1'b0, m_err = 1'b0;
  int         m_edges = 0;
  logic [1:0] abq[$];
  int         delta;
  logic       m_up, m_dn, m_ill;

  function automatic int phase_idx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos = '0; m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0; m_edges = 0;
      abq.delete();
    end else begin
      abq.push_back({a, b});
      if (abq.size() > 4) void'(abq.pop_front());
      if (m_edges < 1000) m_edges++;
      m_up = 1'b0; m_dn = 1'b0; m_ill = 1'b0;
      if (m_edges >= 4) begin
        delta = (phase_idx(abq[1]) - phase_idx(abq[0]) + 4) % 4;
        m_up  = (delta == 1);
        m_dn  = (delta == 3);
        m_ill = (delta == 2);
      end
      m_step = 1'b0;
      if (clr) begin
        m_pos = '0; m_err = 1'b0;
      end else if (load) begin
        m_pos = d;
        if (m_ill) m_err = 1'b1;
      end else begin
        if (m_ill) m_err = 1'b1;
        if (en && (m_up || m_dn)) begin
          m_pos  = m_up ? m_pos + 8'd1 : m_pos - 8'd1;
          m_step = 1'b1;
          m_dir  = m_up;
        end
      end
    end
  end

  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    reset = 1'b1; {a, b} = ab; en = 1'b1; clr = 1'b0; load = 1'b0; d = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int steps_seen = 0;
    @(negedge clk);
    reset = 1'b1; {a, b} = 2'b11; en = 1'b1; clr = 1'b0; load = 1'b0;
    #1;
    checks++;
    if (pos !== 8'h00 || step !== 1'b0 || dir !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got pos=%h step=%b dir=%b err=%b expected 00 0 0 0", pos, step, dir, err);
    end
    @(negedge clk);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) begin
      tick();
      if (step !== 1'b0) steps_seen++;
    end
    checks++;
    if (steps_seen != 0) begin
      errors++;
      $display("FAIL reset_absorb_step got %0d step pulses expected 0", steps_seen);
    end
    checks++;
    if (pos !== 8'h00 || err !== 1'b0 || min_tick !== 1'b1) begin
      errors++;
      $display("FAIL reset_absorb got pos=%h err=%b min_tick=%b expected 00 0 1", pos, err, min_tick);
    end
  endtask

  task automatic test_up_sequence();
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic       want [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int         pulses = 0;
    do_reset(2'b00);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      {a, b} = seq[i];
      for (int c = 0; c < 4; c++) begin
        tick();
        if (step === 1'b1) pulses++;
        checks++;
        if (step !== want[c]) begin
          errors++;
          $display("FAIL up_latency phase%0d edge%0d got step=%b expected %b", i, c, step, want[c]);
        end
      end
    end
    checks++;
    if (pos !== 8'd4 || dir !== 1'b1 || pulses != 4) begin
      errors++;
      $display("FAIL up_sequence got pos=%h dir=%b pulses=%0d expected 04 1 4", pos, dir, pulses);
    end
  endtask

  task automatic test_wrap();
    do_reset(2'b00);
    repeat (5) tick();
    load = 1'b1; d = 8'hFF;
    tick();
    load = 1'b0;
    checks++;
    if (pos !== 8'hFF || max_tick !== 1'b1 || min_tick !== 1'b0) begin
      errors++;
      $display("FAIL wrap_load got pos=%h max=%b min=%b expected ff 1 0", pos, max_tick, min_tick);
    end
    {a, b} = 2'b01;
    repeat (3) tick();
    checks++;
    if (pos !== 8'h00 || min_tick !== 1'b1 || max_tick !== 1'b0 || step !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up got pos=%h min=%b max=%b step=%b expected 00 1 0 1", pos, min_tick, max_tick, step);
    end
    {a, b} = 2'b00;
    repeat (3) tick();
    checks++;
    if (pos !== 8'hFF || dir !== 1'b0 || max_tick !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down got pos=%h dir=%b max=%b expected ff 0 1", pos, dir, max_tick);
    end
  endtask

  task automatic test_illegal();
    do_reset(2'b00);
    repeat (5) tick();
    load = 1'b1; d = 8'h33;
    tick();
    load = 1'b0;
    {a, b} = 2'b11;
    repeat (2) tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_early got err=%b expected 0", err);
    end
    tick();
    checks++;
    if (err !== 1'b1 || pos !== 8'h33 || step !== 1'b0) begin
      errors++;
      $display("FAIL illegal got err=%b pos=%h step=%b expected 1 33 0", err, pos, step);
    end
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (err !== 1'b0 || pos !== 8'h00) begin
      errors++;
      $display("FAIL illegal_clr got err=%b pos=%h expected 0 00", err, pos);
    end
  endtask

  task automatic test_enable();
    int pulses = 0;
    do_reset(2'b00);
    repeat (5) tick();
    en = 1'b0;
    {a, b} = 2'b01;
    repeat (4) begin tick(); if (step === 1'b1) pulses++; end
    {a, b} = 2'b11;
    repeat (4) begin tick(); if (step === 1'b1) pulses++; end
    checks++;
    if (pos !== 8'h00 || pulses != 0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL enable_off got pos=%h pulses=%0d dir=%b expected 00 0 0", pos, pulses, dir);
    end
    en = 1'b1;
    {a, b} = 2'b01;
    repeat (4) tick();
    checks++;
    if (pos !== 8'hFF || err !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL enable_down got pos=%h err=%b dir=%b expected ff 0 0", pos, err, dir);
    end
  endtask

  task automatic test_load_priority();
    do_reset(2'b00);
    repeat (5) tick();
    {a, b} = 2'b01;
    repeat (2) tick();
    load = 1'b1; d = 8'h40;
    tick();
    load = 1'b0;
    checks++;
    if (pos !== 8'h40 || step !== 1'b0) begin
      errors++;
      $display("FAIL load_vs_step got pos=%h step=%b expected 40 0", pos, step);
    end
    tick();
    checks++;
    if (pos !== 8'h40) begin
      errors++;
      $display("FAIL load_hold got pos=%h expected 40", pos);
    end
    clr = 1'b1; load = 1'b1; d = 8'h55;
    tick();
    clr = 1'b0; load = 1'b0;
    checks++;
    if (pos !== 8'h00) begin
      errors++;
      $display("FAIL clr_vs_load got pos=%h expected 00", pos);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(2'b00);
    repeat (5) tick();
    load = 1'b1; d = 8'h5A;
    tick();
    load = 1'b0;
    {a, b} = 2'b11;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pos !== 8'h00 || err !== 1'b0 || step !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got pos=%h err=%b step=%b dir=%b expected 00 0 0 0", pos, err, step, dir);
    end
    @(negedge clk);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    checks++;
    if (pos !== 8'h00 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_absorb got pos=%h err=%b expected 00 0", pos, err);
    end
  endtask

  task automatic test_random();
    int idx = $urandom_range(0, 3);
    int r;
    do_reset(gray[idx]);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r >= 40 && r < 65)      idx = (idx + 1) % 4;
      else if (r >= 65 && r < 93) idx = (idx + 3) % 4;
      else if (r >= 93)           idx = (idx + 2) % 4;
      {a, b} = gray[idx];
      en   = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 99) < 3);
      load = ($urandom_range(0, 99) < 6);
      d    = 8'($urandom);
      tick();
      checks++;
      if (pos !== m_pos || step !== m_step || dir !== m_dir || err !== m_err) begin
        errors++;
        $display("FAIL random cycle%0d got pos=%h step=%b dir=%b err=%b expected %h %b %b %b",
                 i, pos, step, dir, err, m_pos, m_step, m_dir, m_err);
      end
      checks++;
      if (max_tick !== (m_pos == 8'hFF) || min_tick !== (m_pos == 8'h00)) begin
        errors++;
        $display("FAIL random_ticks cycle%0d got max=%b min=%b for expected pos %h", i, max_tick, min_tick, m_pos);
      end
    end
    clr = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_sequence();
    test_wrap();
    test_illegal();
    test_enable();
    test_load_priority();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter: N, default 8, width of position count.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a  input  1  quadrature channel A, asynchronous to clk.
REQ-005 b  input  1  quadrature channel B, asynchronous to clk.
REQ-006 en  input  1  count enable; 0 = track phase without counting.
REQ-007 clr  input  1  synchronous clear of pos and err.
REQ-008 load  input  1  synchronous load of pos from d.
REQ-009 d  input  N  load value.
REQ-010 pos  output  N  registered position count.
REQ-011 step  output  1  registered one-cycle pulse per counted transition.
REQ-012 dir  output  1  registered direction of last counted step; 1 = up.
REQ-013 err  output  1  sticky illegal-transition flag.
REQ-014 max_tick  output  1  high while pos == 2^N-1.
REQ-015 min_tick  output  1  high while pos == 0.

Function
REQ-016 The block SHALL pass {a,b} through a two-flop synchronizer (s1 then s2) before any decode.
REQ-017 The block SHALL hold a previous-phase register prev, updated from s2 every cycle.
REQ-018 The block SHALL use FSM states INIT and RUN.
REQ-019 INIT: no decode, no step, no err; prev <= s2 each cycle; 2-bit fill counter increments.
REQ-020 INIT -> RUN on the third rising edge after reset deassertion; RUN is held until reset.
REQ-021 RUN decode, {prev,s2} as {a,b}: 00->01, 01->11, 11->10, 10->00 = up step.
REQ-022 RUN decode: 00->10, 10->11, 11->01, 01->00 = down step.
REQ-023 RUN decode: prev == s2 = no step, pos held.
REQ-024 RUN decode: both bits changed (00<->11, 01<->10) = illegal; err set to 1, no step, pos held.
REQ-025 Latency: a or b change sampled into s1 at edge k SHALL update pos, step, dir at edge k+2.
REQ-026 Counted step with en=1: pos +1 (up) or -1 (down), modulo 2^N; step=1 for one cycle; dir updated.
REQ-027 Wrap: up from 2^N-1 SHALL give 0; down from 0 SHALL give 2^N-1; no saturation.
REQ-028 Legal transition with en=0: prev still tracks, pos held, step=0, dir held.
REQ-029 Illegal transitions SHALL set err regardless of en.
REQ-030 Priority: clr > load > decoded step.
REQ-031 clr=1: pos <= 0, err <= 0, step=0; any coincident step is discarded.
REQ-032 load=1 (clr=0): pos <= d, step=0, err unchanged; any coincident step is discarded.
REQ-033 clr and load SHALL act in INIT and in RUN.
REQ-034 Coincident illegal transition and clr: clr wins, err=0.
REQ-035 max_tick and min_tick SHALL be combinational decodes of pos only.

Reset
REQ-036 reset=1 SHALL immediately force s1=s2=prev=00, pos=0, step=0, dir=0, err=0, fill=0, state INIT.
REQ-037 Reset asserted mid-operation SHALL abort all activity and re-enter INIT.
REQ-038 Input phase present at reset release (e.g. 11) SHALL be absorbed in INIT and SHALL NOT set err or count.

Verification
REQ-039 Reset with ab=11 held, release, wait 5 cycles -> pos=0, err=0, step never asserted.
REQ-040 en=1, ab sequence 00,01,11,10,00, 4 clk per phase -> pos 0->4, four step pulses, dir=1, each 2 edges after s1 capture.
REQ-041 N=8, load d=8'hFF, then one up step -> max_tick=1 before the step; after it pos=0, min_tick=1; then one down step -> pos=8'hFF.
REQ-042 ab 00->11 in one cycle -> err=1 and pos unchanged; later clr -> err=0, pos=0.
REQ-043 en=0 during two up steps, then en=1 and one down step -> pos=-1 mod 256 = 8'hFF, err=0.
REQ-044 load=1, d=8'h40 on the same edge as a decoded up step -> pos=8'h40, step=0; clr+load together -> pos=0.
